// File: rtl/keypad_if.sv
// Keypad scanner signal bundle: matrix drive/sense, digit-entry results and FSM debug view.
// Handshake: key_valid is a single-cycle strobe with no ready; key_code and num are stable from that cycle on.
interface keypad_if;
    logic [3:0]  row;
    logic [3:0]  col;
    logic        clear;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        pressed;
    logic [31:0] num;
    logic [1:0]  fsm_state;

    modport master (
        output row, key_code, key_valid, pressed, num, fsm_state,
        input  col, clear
    );

    modport slave (
        input  row, key_code, key_valid, pressed, num, fsm_state,
        output col, clear
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 hex keypad scanner: row scan, per-scan snapshot, scan-count debounce,
// and shift of accepted digits into a 32-bit display number.
module keypad_scan #(
    parameter int SCAN_DIV = 25000,
    parameter int DEBOUNCE = 4
) (
    input  logic      clk,
    input  logic      rst,
    keypad_if.master  bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE + 1);

    typedef enum logic [1:0] {IDLE, PCHK, HELD, RCHK} state_t;

    logic [SW-1:0] slot;
    logic [1:0]    row_idx;
    logic [3:0]    row_q;
    logic [3:0]    sync1;
    logic [3:0]    sync2;
    logic          tc;
    logic          scan_done;

    assign tc        = (slot == SW'(SCAN_DIV - 1));
    assign scan_done = tc && (row_idx == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot    <= '0;
            row_idx <= 2'd0;
            row_q   <= 4'b1110;
            sync1   <= 4'b1111;
            sync2   <= 4'b1111;
        end else begin
            sync1 <= bus.col;
            sync2 <= sync1;
            if (tc) begin
                slot    <= '0;
                row_idx <= row_idx + 2'd1;
                row_q   <= ~(4'b0001 << (row_idx + 2'd1));
            end else begin
                slot <= slot + SW'(1);
            end
        end
    end

    // Hit counting saturates at 2: only none / one / many matters.
    logic [2:0] slot_hits;
    logic [1:0] slot_col;
    logic [2:0] hit_sum;
    logic [1:0] seen_hits;
    logic [3:0] seen_code;
    logic [1:0] acc_hits;
    logic [3:0] acc_code;

    always_comb begin
        slot_hits = 3'd0;
        slot_col  = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!sync2[i]) begin
                slot_hits = slot_hits + 3'd1;
                slot_col  = 2'(i);
            end
        end
        hit_sum   = {1'b0, acc_hits} + slot_hits;
        seen_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        seen_code = (acc_hits == 2'd1) ? acc_code : {row_idx, slot_col};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_hits <= 2'd0;
            acc_code <= 4'd0;
        end else if (tc) begin
            acc_hits <= (row_idx == 2'd3) ? 2'd0 : seen_hits;
            acc_code <= seen_code;
        end
    end

    logic res_none;
    logic res_single;
    assign res_none   = (seen_hits == 2'd0);
    assign res_single = (seen_hits == 2'd1);

    state_t        state, state_next;
    logic [CW-1:0] cnt, cnt_next, cnt_inc;
    logic [3:0]    cand, cand_next;
    logic          strobe;

    assign cnt_inc = cnt + CW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            cand  <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            cand  <= cand_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        cand_next  = cand;
        strobe     = 1'b0;
        if (scan_done) begin
            case (state)
                IDLE: begin
                    if (res_single) begin
                        cand_next  = seen_code;
                        cnt_next   = CW'(1);
                        state_next = PCHK;
                    end
                end
                PCHK: begin
                    if (res_single && seen_code == cand) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) begin
                            strobe     = 1'b1;
                            state_next = HELD;
                        end
                    end else begin
                        state_next = IDLE;
                    end
                end
                HELD: begin
                    if (res_none) begin
                        cnt_next   = CW'(1);
                        state_next = RCHK;
                    end
                end
                RCHK: begin
                    if (res_none) begin
                        cnt_next = cnt_inc;
                        if (cnt_inc == CW'(DEBOUNCE)) state_next = IDLE;
                    end else begin
                        state_next = HELD;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    logic [3:0]  key_code_q;
    logic        key_valid_q;
    logic        pressed_q;
    logic [31:0] num_q;

    // Clear wins over a same-cycle shift; the strobe itself still goes out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            pressed_q   <= 1'b0;
            num_q       <= 32'd0;
        end else begin
            key_valid_q <= strobe;
            pressed_q   <= (state_next == HELD) || (state_next == RCHK);
            if (strobe) key_code_q <= cand;
            if (bus.clear)   num_q <= 32'd0;
            else if (strobe) num_q <= {num_q[27:0], cand};
        end
    end

    assign bus.row       = row_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_valid = key_valid_q;
    assign bus.pressed   = pressed_q;
    assign bus.num       = num_q;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3) with a matrix model
// that pulls col[c] low while row r is driven low and key r*4+c is held.
module tb_keypad_scan;
    logic        clk;
    logic        rst;
    logic [15:0] keys;
    logic [3:0]  col_model;
    int          n_cmp;
    int          n_bad;
    int          pulse_total;

    keypad_if bus ();

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        col_model = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!bus.row[r] && keys[r*4+c]) col_model[c] = 1'b0;
    end
    assign bus.col = col_model;

    always @(negedge clk) if (!rst && bus.key_valid) pulse_total++;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reset with keys already applied; the next posedge is cycle 1 of the scan.
    task automatic do_reset(input logic [15:0] k);
        @(negedge clk);
        rst  = 1'b1;
        keys = k;
        @(negedge clk);
        rst  = 1'b0;
    endtask

    task automatic wait_pulse(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (bus.key_valid) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic wait_release(input int limit, output int cycles);
        cycles = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            #1;
            if (!bus.pressed) begin
                cycles = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int cyc;
        #1;
        if (bus.row !== 4'b1110) begin $display("FAIL rst_row: got %b want 1110", bus.row); n_bad++; end
        n_cmp++;
        if (bus.key_code !== 4'd0) begin $display("FAIL rst_key_code: got %h want 0", bus.key_code); n_bad++; end
        n_cmp++;
        if (bus.key_valid !== 1'b0) begin $display("FAIL rst_key_valid: got %b want 0", bus.key_valid); n_bad++; end
        n_cmp++;
        if (bus.pressed !== 1'b0) begin $display("FAIL rst_pressed: got %b want 0", bus.pressed); n_bad++; end
        n_cmp++;
        if (bus.num !== 32'd0) begin $display("FAIL rst_num: got %h want 0", bus.num); n_bad++; end
        n_cmp++;

        // Abort mid-PCHK: after scan 0 the FSM sits in PCHK.
        do_reset(16'h0040);
        repeat (20) @(posedge clk);
        #2;
        if (bus.fsm_state !== 2'd1) begin $display("FAIL pchk_state: got %0d want 1", bus.fsm_state); n_bad++; end
        n_cmp++;
        rst = 1'b1;
        #1;
        if (bus.row !== 4'b1110) begin $display("FAIL pchk_rst_row: got %b want 1110", bus.row); n_bad++; end
        n_cmp++;
        if (bus.fsm_state !== 2'd0) begin $display("FAIL pchk_rst_state: got %0d want 0", bus.fsm_state); n_bad++; end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
        wait_pulse(100, cyc);
        if (cyc !== 48) begin $display("FAIL pchk_restart_latency: got %0d want 48", cyc); n_bad++; end
        n_cmp++;

        // Abort mid-HELD: outputs drop asynchronously.
        #2;
        rst = 1'b1;
        #1;
        if (bus.num !== 32'd0) begin $display("FAIL held_rst_num: got %h want 0", bus.num); n_bad++; end
        n_cmp++;
        if (bus.key_code !== 4'd0) begin $display("FAIL held_rst_key_code: got %h want 0", bus.key_code); n_bad++; end
        n_cmp++;
        if (bus.pressed !== 1'b0 || bus.key_valid !== 1'b0) begin
            $display("FAIL held_rst_flags: got pressed=%b valid=%b want 0/0", bus.pressed, bus.key_valid); n_bad++;
        end
        n_cmp++;
        if (bus.row !== 4'b1110) begin $display("FAIL held_rst_row: got %b want 1110", bus.row); n_bad++; end
        n_cmp++;
        @(negedge clk);
        rst = 1'b0;
        wait_pulse(100, cyc);
        if (cyc !== 48) begin $display("FAIL held_restart_latency: got %0d want 48", cyc); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_single_press();
        int cyc;
        int p0;
        p0 = pulse_total;
        do_reset(16'h0040);
        wait_pulse(100, cyc);
        if (cyc !== 48) begin $display("FAIL press_latency: got %0d want 48", cyc); n_bad++; end
        n_cmp++;
        if (bus.key_code !== 4'd6) begin $display("FAIL press_key_code: got %h want 6", bus.key_code); n_bad++; end
        n_cmp++;
        if (bus.num !== 32'h0000_0006) begin $display("FAIL press_num: got %h want 00000006", bus.num); n_bad++; end
        n_cmp++;
        if (bus.pressed !== 1'b1) begin $display("FAIL press_pressed: got %b want 1", bus.pressed); n_bad++; end
        n_cmp++;
        @(posedge clk);
        #1;
        if (bus.key_valid !== 1'b0) begin $display("FAIL press_pulse_width: got %b want 0", bus.key_valid); n_bad++; end
        n_cmp++;
        repeat (319) @(posedge clk);
        #1;
        if (pulse_total - p0 !== 1) begin $display("FAIL hold_no_repeat: got %0d pulses want 1", pulse_total - p0); n_bad++; end
        n_cmp++;
        keys = 16'h0000;
        wait_release(100, cyc);
        if (cyc !== 48) begin $display("FAIL release_latency: got %0d want 48", cyc); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_wrap();
        int cyc;
        int p0;
        p0 = pulse_total;
        do_reset(16'h0000);
        for (int k = 1; k <= 9; k++) begin
            keys = 16'(1 << k);
            wait_pulse(100, cyc);
            if (bus.key_code !== 4'(k)) begin $display("FAIL wrap_key_code_%0d: got %h want %h", k, bus.key_code, k); n_bad++; end
            n_cmp++;
            keys = 16'h0000;
            wait_release(100, cyc);
            if (cyc < 0) begin $display("FAIL wrap_release_%0d: got timeout want release", k); n_bad++; end
            n_cmp++;
        end
        if (bus.num !== 32'h2345_6789) begin $display("FAIL wrap_num: got %h want 23456789", bus.num); n_bad++; end
        n_cmp++;
        if (pulse_total - p0 !== 9) begin $display("FAIL wrap_pulses: got %0d want 9", pulse_total - p0); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_bounce();
        int cyc;
        int p0;
        logic all_high;
        // Two matching scans only, then released.
        p0 = pulse_total;
        do_reset(16'h0020);
        repeat (32) @(posedge clk);
        #1;
        keys = 16'h0000;
        repeat (100) @(posedge clk);
        #1;
        if (pulse_total - p0 !== 0) begin $display("FAIL short_press_pulses: got %0d want 0", pulse_total - p0); n_bad++; end
        n_cmp++;
        if (bus.pressed !== 1'b0) begin $display("FAIL short_press_pressed: got %b want 0", bus.pressed); n_bad++; end
        n_cmp++;

        // One-scan open glitch while held.
        p0 = pulse_total;
        do_reset(16'h0020);
        wait_pulse(100, cyc);
        if (cyc !== 48) begin $display("FAIL glitch_first_latency: got %0d want 48", cyc); n_bad++; end
        n_cmp++;
        all_high = 1'b1;
        keys = 16'h0000;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (!bus.pressed) all_high = 1'b0;
        end
        keys = 16'h0020;
        repeat (64) begin
            @(posedge clk);
            #1;
            if (!bus.pressed) all_high = 1'b0;
        end
        if (all_high !== 1'b1) begin $display("FAIL glitch_pressed: got drop want steady 1"); n_bad++; end
        n_cmp++;
        if (pulse_total - p0 !== 1) begin $display("FAIL glitch_pulses: got %0d want 1", pulse_total - p0); n_bad++; end
        n_cmp++;
    endtask

    task automatic test_multi_clear();
        int cyc;
        int p0;
        p0 = pulse_total;
        do_reset(16'h0801);
        repeat (100) @(posedge clk);
        #1;
        if (pulse_total - p0 !== 0) begin $display("FAIL multi_pulses: got %0d want 0", pulse_total - p0); n_bad++; end
        n_cmp++;
        if (bus.pressed !== 1'b0 || bus.num !== 32'd0) begin
            $display("FAIL multi_state: got pressed=%b num=%h want 0/0", bus.pressed, bus.num); n_bad++;
        end
        n_cmp++;

        // Key 3 strobes at cycle 48; key A then strobes at cycle 144.
        do_reset(16'h0008);
        wait_pulse(100, cyc);
        if (cyc !== 48 || bus.num !== 32'h3) begin $display("FAIL clear_seed: got cyc=%0d num=%h want 48/3", cyc, bus.num); n_bad++; end
        n_cmp++;
        keys = 16'h0000;
        repeat (48) @(posedge clk);
        #1;
        if (bus.pressed !== 1'b0) begin $display("FAIL clear_seed_release: got %b want 0", bus.pressed); n_bad++; end
        n_cmp++;
        keys = 16'h0400;
        repeat (47) @(posedge clk);
        #1;
        bus.clear = 1'b1;
        @(posedge clk);
        #1;
        bus.clear = 1'b0;
        if (bus.key_valid !== 1'b1) begin $display("FAIL clear_valid: got %b want 1", bus.key_valid); n_bad++; end
        n_cmp++;
        if (bus.key_code !== 4'hA) begin $display("FAIL clear_key_code: got %h want a", bus.key_code); n_bad++; end
        n_cmp++;
        if (bus.num !== 32'd0) begin $display("FAIL clear_num: got %h want 0", bus.num); n_bad++; end
        n_cmp++;
    endtask

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        pulse_total = 0;
        rst         = 1'b1;
        keys        = 16'h0000;
        bus.clear   = 1'b0;
        test_reset();
        test_single_press();
        test_wrap();
        test_bounce();
        test_multi_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 hex matrix keypad, debounces it, and assembles the keys entered into a 32-bit hex number. It is the input side of the board's seven-segment path: its `num` output feeds the 8-digit display driver, so typed digits appear on the display. Each debounced press yields one key code and one single-cycle strobe.

## Interface

**Parameters**
- `SCAN_DIV`, default 25000: clk cycles per row slot. Must be ≥ 4.
- `DEBOUNCE`, default 4: number of consecutive identical full scans needed to accept a press or a release. Must be ≥ 2.

**Ports**
- `clk` input 1: system clock.
- `rst` input 1: reset, asynchronous, active-high.
- `row` output 4: row drive, active-low. Exactly one bit is low at a time.
- `col` input 4: column sense, active-low, pulled up externally. Asynchronous to `clk`.
- `clear` input 1: synchronous clear of `num`.
- `key_code` output 4: last accepted key, encoded as row_idx*4 + col_idx.
- `key_valid` output 1: one-cycle strobe when a press is accepted.
- `pressed` output 1: level, high while an accepted key is held.
- `num` output 32: entered digits. The newest digit is in [3:0].

## Operation

**Row scan**
- Slot counter runs 0..SCAN_DIV-1. At terminal count it wraps and `row_idx` advances 0→1→2→3→0.
- `row` = ~(1 << row_idx).
- `col` passes through a 2-flop synchronizer.
- The synchronized value is sampled on the slot's terminal-count cycle, i.e. after the row has settled.

**Snapshot (built per full scan)**
- Count the active-low column bits seen across all 4 slots.
- Exactly one active bit: result is SINGLE(code).
- None: result is NONE.
- More than one: result is MULTI.
- The snapshot is evaluated on the terminal cycle of row 3.

**Debounce FSM** (`cnt` counts consecutive scans)
- IDLE:
  - SINGLE(k): cand=k, cnt=1, go to PCHK.
  - NONE or MULTI: stay.
- PCHK:
  - SINGLE(cand): cnt++. When cnt reaches DEBOUNCE: strobe, go to HELD.
  - Any other result: go to IDLE.
- HELD:
  - NONE: cnt=1, go to RCHK.
  - SINGLE or MULTI: stay. A held key never re-strobes.
- RCHK:
  - NONE: cnt++. When cnt reaches DEBOUNCE: go to IDLE.
  - SINGLE or MULTI: go to HELD.
- `pressed` = state is HELD or RCHK.

**Strobe actions** (all in the same cycle)
- `key_valid`=1.
- `key_code`=cand.
- `num` = {num[27:0], cand}. The oldest digit drops off; there is no saturation.

**Clear**
- `clear`=1 sets `num` to 0 next edge.
- `clear` has priority over a concurrent shift.
- `key_valid` and `key_code` still update normally.

**Reset**
- Asserting `rst` at any time, including mid-debounce or mid-held, aborts the operation.
- No strobe is issued after `rst` is released until a fresh DEBOUNCE-scan press completes.

## Timing

**Reset values**
- `row`=4'b1110, `key_code`=0, `key_valid`=0, `pressed`=0, `num`=0.
- FSM=IDLE, slot counter=0, `row_idx`=0, synchronizer flops=4'b1111.

**Scan period**
- 4*SCAN_DIV cycles.

**Sample alignment**
- The value sampled reflects `col` 2 cycles earlier, which still falls within the same slot.

**Press latency**
- `key_valid` rises 1 clk after the row-3 terminal cycle of the DEBOUNCE-th consecutive matching scan.
- `key_valid` lasts exactly 1 cycle.
- `num` and `key_code` change on the same edge that `key_valid` rises.

**Release**
- `pressed` falls 1 clk after the DEBOUNCE-th consecutive NONE scan.

**Outputs**
- All outputs are registered.
- There are no combinational paths from `col` or `clear` to any output.

## Test plan

All scenarios use SCAN_DIV=4, DEBOUNCE=3, and a keypad model that pulls `col[c]` low while row r is driven low.

1. **Reset.** Assert `rst` asynchronously mid-PCHK and mid-HELD.
   - Outputs show their reset values immediately, before any clk edge.
   - `row`=1110.
   - No `key_valid` follows until 3 fresh full scans complete.
2. **Single press.** Press r1,c2 steadily.
   - Exactly one `key_valid` pulse, 1 cycle after the third scan (≈48 cycles).
   - `key_code`=6, `num`=0x00000006, `pressed`=1.
   - Holding for 20 more scans produces no further pulse.
   - After release, `pressed` falls after 3 NONE scans.
3. **Wrap-around.** Enter keys 1,2,3,4,5,6,7,8,9 in sequence, releasing fully between each.
   - `num`=0x23456789.
   - Exactly 9 `key_valid` pulses.
4. **Bounce.**
   - Press held for only 2 scans, then released: no `key_valid`.
   - During HELD, a 1-scan open glitch: no second pulse and `pressed` stays 1.
5. **Multi-key and clear.**
   - r0,c0 and r2,c3 pressed together: no `key_valid`.
   - `clear` asserted on the strobe cycle of key 0xA: `num`=0, `key_code`=0xA, `key_valid`=1.
